axil_fifo_mc: RTL and testbench
===============================

Name: axil_fifo_mc

Overview:
AXI4-Lite write-slave that steers each accepted write beat into one of NUM_CH independent show-ahead FIFOs. The target FIFO is selected by address decode. The block adds the following:
- independent AW/W acceptance
- stall-on-full back-pressure
- SLVERR responses for bad addresses
- an AXI-Lite read channel that returns per-channel fill level

It sits between the interconnect and the consumer engines that drain the fif_* ports.

Parameters:
MEM_BASE, 32'h10000000, base address of channel 0 push register
DATA_WIDTH, 32, AXI data width and FIFO data width
ADDR_WIDTH, 32, AXI address width
STRB_WIDTH, DATA_WIDTH/8, strobe width; stored alongside data as fif_den
NUM_CH, 2, number of FIFOs (1..8)
DEPTH, 4, entries per FIFO; power of two, >=2
CH_STRIDE, 32'h4, address distance between channel registers; power of two, >=STRB_WIDTH

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  reset, asynchronous assert, active-low
axi_awaddr  in  ADDR_WIDTH  write address
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_wdata  in  DATA_WIDTH  write data
axi_wstrb  in  STRB_WIDTH  write strobes
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready
axi_araddr  in  ADDR_WIDTH  read address
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_rdata  out  DATA_WIDTH  read data (status)
axi_rresp  out  2  read response
axi_rvalid  out  1  read valid
axi_rready  in  1  read ready
fif_pop  in  NUM_CH  per-channel pop of head entry
fif_dat  out  NUM_CH*DATA_WIDTH  head data; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
fif_den  out  NUM_CH*STRB_WIDTH  head strobes, packed the same way
fif_val  out  NUM_CH  channel k non-empty

Behaviour:
- Reset (rst_n low, async): all FIFOs empty, all holding regs empty. Outputs during reset:
  - axi_bvalid=0, axi_bresp=0
  - axi_rvalid=0, axi_rresp=0, axi_rdata=0
  - fif_val=0, fif_dat=0, fif_den=0
  - axi_awready=1, axi_wready=1
  - In-flight write or read is discarded with no response.
- Write acceptance: AW and W each have a one-entry holding register.
  - axi_awready = !aw_held; axi_wready = !w_held.
  - Either channel may arrive first or both in the same cycle.
- Decode: off = awaddr - MEM_BASE. Address is valid iff awaddr >= MEM_BASE, off % CH_STRIDE == 0, and off/CH_STRIDE < NUM_CH. ch = off/CH_STRIDE.
- Commit: occurs on the edge where aw_held & w_held & !axi_bvalid & (invalid | !full[ch]).
  - Valid address: push {wdata,wstrb} into FIFO ch; bresp=OKAY.
  - Invalid address: drop the data; bresp=SLVERR.
  - Commit clears both holding regs and sets axi_bvalid.
  - Minimum latency: AW+W accepted at edge N, commit at edge N+1, bvalid high after edge N+1.
- Full: a valid write to a full channel waits in the holding regs with no bvalid. Commit on the first edge where full[ch] is low as sampled. full is the registered state; a pop in the same cycle does not allow a push in that cycle.
- Response: axi_bvalid and axi_bresp are held stable until axi_bready. One write outstanding; no new commit while bvalid=1. The holding regs may still accept the next AW/W while bvalid=1.
- FIFO: circular buffer, DEPTH entries, count width $clog2(DEPTH+1).
  - fif_val[k] = count!=0.
  - fif_dat/fif_den show the head entry combinationally from storage; value is 0 when empty.
  - Pop when empty is ignored.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged, both pointers advance.
  - Pointers wrap at DEPTH.
- Status read: arready = !axi_rvalid. The AR address is decoded with the same rule.
  - Valid address: rdata = {zero-pad, full[ch], count[ch]} with count in the LSBs and full at bit $clog2(DEPTH+1); rresp=OKAY.
  - Invalid address: rdata=0, rresp=SLVERR.
  - rvalid is set on the edge after AR handshake and held until rready.
  - Count is sampled at the AR handshake edge.
- Reads and writes are fully independent.

Test Plan:
1. AW+W same cycle, addr 0x10000000, wdata 0xDEADBEEF, wstrb 0xF, bready=1 → bvalid one cycle after acceptance with bresp 00; fif_val[0]=1; fif_dat[31:0]=0xDEADBEEF; fif_den[3:0]=0xF.
2. W sent 3 cycles before AW to 0x10000004 (ch1) → wready drops after W accepted; single OKAY response; fif_val[1]=1; ch0 unaffected.
3. Write 0x10000008 (out of range, NUM_CH=2), then 0x10000002 (misaligned) → two SLVERR responses; no fif_val change.
4. Five writes to ch0 with no pops (DEPTH=4) → first four OKAY; fifth holds with awready=0, wready=0 and no bvalid. Pop once → fifth commits the following cycle with OKAY; popped entry is write 1; remaining order 2,3,4,5.
5. Read 0x10000000 with ch0 holding 4 entries → rdata=0x0000000C (full=1 at bit 3, count=4), rresp 00. Read 0x10000010 → SLVERR, rdata 0. Hold rready=0 for 3 cycles → rvalid/rdata stable.
6. Assert rst_n low asynchronously mid-stall (test 4 state, before the pop) → bvalid, rvalid, fif_val clear immediately; after release, awready=wready=1 and all counts read 0.

Source files
------------

// File: rtl/axil_fifo_mc_if.sv
`default_nettype none
// ============================================================================
// axil_fifo_mc_if : AXI4-Lite write/read bus bundle for axil_fifo_mc
// Revision 1.0
// ============================================================================
interface axil_fifo_mc_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axil_fifo_mc.sv
`default_nettype none
// ============================================================================
// axil_fifo_mc : AXI4-Lite write slave steering beats into NUM_CH show-ahead FIFOs
// Revision 1.0
// ============================================================================
module axil_fifo_mc #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h1000_0000,
  parameter int unsigned           NUM_CH     = 2,
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           CH_STRIDE  = 32'h4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axil_fifo_mc_if.slave                axi,
  input  logic [NUM_CH-1:0]            fif_pop,
  output logic [NUM_CH*DATA_WIDTH-1:0] fif_dat,
  output logic [NUM_CH*STRB_WIDTH-1:0] fif_den,
  output logic [NUM_CH-1:0]            fif_val
);
  localparam int unsigned     c_PTR_W     = $clog2(DEPTH);
  localparam int unsigned     c_CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned     c_CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned     c_STRIDE_LG = $clog2(CH_STRIDE);
  localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);
  localparam logic [1:0]      c_OKAY      = 2'b00;
  localparam logic [1:0]      c_SLVERR    = 2'b10;

  function automatic logic decode_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - MEM_BASE;
    return (addr >= MEM_BASE)
        && ((off & ADDR_WIDTH'(CH_STRIDE - 1)) == '0)
        && ((off >> c_STRIDE_LG) < ADDR_WIDTH'(NUM_CH));
  endfunction

  function automatic logic [c_CH_W-1:0] decode_ch(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - MEM_BASE;
    return c_CH_W'(off >> c_STRIDE_LG);
  endfunction

  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_WIDTH-1:0] r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [NUM_CH-1:0][c_CNT_W-1:0] w_cnt;
  logic [NUM_CH-1:0]     w_full;
  logic                  w_aw_ok;
  logic [c_CH_W-1:0]     w_aw_ch;
  logic                  w_tgt_full;
  logic                  w_commit;
  logic                  w_ar_ok;
  logic [c_CH_W-1:0]     w_ar_ch;
  logic [DATA_WIDTH-1:0] w_status;

  assign axi.awready = !r_aw_held;
  assign axi.wready  = !r_w_held;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.arready = !r_rvalid;
  assign axi.rvalid  = r_rvalid;
  assign axi.rresp   = r_rresp;
  assign axi.rdata   = r_rdata;

  // Full is the registered state: a same-cycle pop never frees room for a push.
  always_comb begin
    w_aw_ok    = decode_ok(r_aw_addr);
    w_aw_ch    = decode_ch(r_aw_addr);
    w_tgt_full = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_aw_ch == c_CH_W'(k)) w_tgt_full = w_full[k];
    end
    w_commit = r_aw_held && r_w_held && !r_bvalid && (!w_aw_ok || !w_tgt_full);
  end

  always_comb begin
    w_ar_ok  = decode_ok(axi.araddr);
    w_ar_ch  = decode_ch(axi.araddr);
    w_status = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ar_ok && (w_ar_ch == c_CH_W'(k))) begin
        w_status[c_CNT_W-1:0] = w_cnt[k];
        w_status[c_CNT_W]     = w_full[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_OKAY;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
      end else if (axi.awvalid && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= axi.awaddr;
      end
      if (w_commit) begin
        r_w_held <= 1'b0;
      end else if (axi.wvalid && !r_w_held) begin
        r_w_held <= 1'b1;
        r_w_data <= axi.wdata;
        r_w_strb <= axi.wstrb;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_ok ? c_OKAY : c_SLVERR;
      end else if (r_bvalid && axi.bready) begin
        r_bvalid <= 1'b0;
        r_bresp  <= c_OKAY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= c_OKAY;
      r_rdata  <= '0;
    end else if (axi.arvalid && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_ar_ok ? c_OKAY : c_SLVERR;
      r_rdata  <= w_status;
    end else if (r_rvalid && axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DATA_WIDTH-1:0] r_mem_dat [DEPTH];
      logic [STRB_WIDTH-1:0] r_mem_den [DEPTH];
      logic [c_PTR_W-1:0]    r_wptr;
      logic [c_PTR_W-1:0]    r_rptr;
      logic [c_CNT_W-1:0]    r_cnt;
      logic                  w_push;
      logic                  w_pop;

      assign w_push    = w_commit && w_aw_ok && (w_aw_ch == c_CH_W'(k));
      assign w_pop     = fif_pop[k] && (r_cnt != '0);
      assign w_cnt[k]  = r_cnt;
      assign w_full[k] = (r_cnt == c_FULL);
      assign fif_val[k] = (r_cnt != '0);
      assign fif_dat[k*DATA_WIDTH +: DATA_WIDTH] = fif_val[k] ? r_mem_dat[r_rptr] : '0;
      assign fif_den[k*STRB_WIDTH +: STRB_WIDTH] = fif_val[k] ? r_mem_den[r_rptr] : '0;

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem_dat[r_wptr] <= r_w_data;
          r_mem_den[r_wptr] <= r_w_strb;
        end
      end

      // Power-of-two depth lets the pointers wrap naturally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + 1'b1;
          if (w_pop)  r_rptr <= r_rptr + 1'b1;
          if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
          else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_axil_fifo_mc.sv
`default_nettype none
// ============================================================================
// tb_axil_fifo_mc : directed self-checking bench for axil_fifo_mc
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axil_fifo_mc;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    fif_pop;
  logic [NCH*DW-1:0] fif_dat;
  logic [NCH*SW-1:0] fif_den;
  logic [NCH-1:0]    fif_val;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axil_fifo_mc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) axi ();

  axil_fifo_mc #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .MEM_BASE(32'h1000_0000),
    .NUM_CH(NCH), .DEPTH(4), .CH_STRIDE(32'h4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .axi(axi),
    .fif_pop(fif_pop), .fif_dat(fif_dat), .fif_den(fif_den), .fif_val(fif_val)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [1:0]  val;
    logic [31:0] dat0;
  } wvec_t;

  wvec_t vec [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following AW and W acceptance.
  task automatic write_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int   t;
    logic aw_hs, w_hs;
    t = 0;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    while ((axi.awvalid || axi.wvalid) && t < 20) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(negedge clk);
      if (aw_hs) axi.awvalid = 1'b0;
      if (w_hs)  axi.wvalid  = 1'b0;
      t++;
    end
    check("aw_w_accepted", {axi.awvalid, axi.wvalid}, 2'b00);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output int lat);
    lat = 0;
    while (!axi.bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    resp = axi.bresp;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int t;
    t = 0;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b0;
    check("arready", axi.arready, 1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    while (!axi.rvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rvalid", axi.rvalid, 1);
    check("rdata", axi.rdata, exp_data);
    check("rresp", axi.rresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", axi.rvalid, 1);
      check("rdata_hold", axi.rdata, exp_data);
    end
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check("rvalid_clear", axi.rvalid, 0);
  endtask

  task automatic pop(input logic [NCH-1:0] m);
    fif_pop = m;
    @(negedge clk);
    fif_pop = '0;
  endtask

  task automatic fill_and_stall(input logic [31:0] base);
    logic [1:0] r;
    int         l;
    for (int i = 0; i < 4; i++) begin
      write_issue(32'h1000_0000, base + 32'(i), 4'hF);
      wait_b(r, l);
      check("fill_resp", r, 2'b00);
      check("fill_lat", l, 1);
    end
    write_issue(32'h1000_0000, base + 32'd4, 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    logic [1:0] r;
    int         l;

    vec[0] = '{32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 2'b00, 2'b01, 32'hDEAD_BEEF};
    vec[1] = '{32'h1000_0008, 32'h1111_1111, 4'hF, 2'b10, 2'b01, 32'hDEAD_BEEF};
    vec[2] = '{32'h1000_0002, 32'h2222_2222, 4'hF, 2'b10, 2'b01, 32'hDEAD_BEEF};
    vec[3] = '{32'h0FFF_FFFC, 32'h3333_3333, 4'h1, 2'b10, 2'b01, 32'hDEAD_BEEF};

    fif_pop = '0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_awready", axi.awready, 1);
    check("rst_wready", axi.wready, 1);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_fif_val", fif_val, 0);
    check("rst_fif_dat", fif_dat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat writes: one good, three bad addresses.
    for (int i = 0; i < 4; i++) begin
      write_issue(vec[i].addr, vec[i].data, vec[i].strb);
      check("vec_bvalid_early", axi.bvalid, 0);
      wait_b(r, l);
      check("vec_bresp", r, vec[i].resp);
      check("vec_blat", l, 1);
      check("vec_fif_val", fif_val, vec[i].val);
      check("vec_fif_dat0", fif_dat[31:0], vec[i].dat0);
      check("vec_fif_den0", fif_den[3:0], 4'hF);
    end

    // W three cycles ahead of AW, to channel 1.
    axi.wdata = 32'hCAFE_0001; axi.wstrb = 4'h3; axi.wvalid = 1'b1;
    @(negedge clk);
    axi.wvalid = 1'b0;
    check("wfirst_wready", axi.wready, 0);
    check("wfirst_awready", axi.awready, 1);
    repeat (2) @(negedge clk);
    check("wfirst_no_b", axi.bvalid, 0);
    axi.awaddr = 32'h1000_0004; axi.awvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    wait_b(r, l);
    check("wfirst_bresp", r, 2'b00);
    check("wfirst_blat", l, 1);
    check("wfirst_fif_val", fif_val, 2'b11);
    check("wfirst_dat1", fif_dat[63:32], 32'hCAFE_0001);
    check("wfirst_den1", fif_den[7:4], 4'h3);
    check("wfirst_dat0", fif_dat[31:0], 32'hDEAD_BEEF);

    pop(2'b11);
    check("drain_val", fif_val, 2'b00);
    check("drain_dat", fif_dat, 0);
    check("drain_den", fif_den, 0);

    // Fill channel 0 and stall a fifth write.
    fill_and_stall(32'hA000_0001);
    repeat (3) begin
      @(negedge clk);
      check("stall_awready", axi.awready, 0);
      check("stall_wready", axi.wready, 0);
      check("stall_bvalid", axi.bvalid, 0);
    end
    check("stall_head", fif_dat[31:0], 32'hA000_0001);

    do_read(32'h1000_0000, 0, 32'h0000_000C, 2'b00);
    do_read(32'h1000_0010, 3, 32'h0000_0000, 2'b10);
    do_read(32'h1000_0004, 0, 32'h0000_0000, 2'b00);

    pop(2'b01);
    check("pop_head", fif_dat[31:0], 32'hA000_0002);
    check("pop_no_same_cycle_b", axi.bvalid, 0);
    wait_b(r, l);
    check("unstall_bresp", r, 2'b00);
    check("unstall_blat", l, 1);
    for (int i = 1; i < 5; i++) begin
      check("order_val", fif_val[0], 1);
      check("order_dat", fif_dat[31:0], 32'hA000_0001 + 32'(i));
      pop(2'b01);
    end
    check("order_empty", fif_val, 2'b00);

    // Asynchronous reset in the middle of a stall with a read response pending.
    fill_and_stall(32'hB000_0001);
    axi.araddr = 32'h1000_0000; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("pre_rst_rvalid", axi.rvalid, 1);
    check("pre_rst_fif_val", fif_val, 2'b01);
    check("pre_rst_awready", axi.awready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bvalid", axi.bvalid, 0);
    check("arst_rvalid", axi.rvalid, 0);
    check("arst_rdata", axi.rdata, 0);
    check("arst_fif_val", fif_val, 0);
    check("arst_fif_dat", fif_dat, 0);
    check("arst_awready", axi.awready, 1);
    check("arst_wready", axi.wready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_bvalid", axi.bvalid, 0);
    do_read(32'h1000_0000, 0, 32'h0000_0000, 2'b00);
    do_read(32'h1000_0004, 0, 32'h0000_0000, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
